// File: rtl/simd_pkg.sv
// Shared definitions for the packed-SIMD add/sub engine: the operation mode
// encodings and the sequencer state encoding.
package simd_pkg;

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_ADDS = 2'b10;
  localparam logic [1:0] MODE_SUBS = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } simd_state_t;

  // Bit 0 of the mode selects subtraction, bit 1 selects saturation.
  function automatic logic mode_is_sub(input logic [1:0] mode);
    return mode[0];
  endfunction

  function automatic logic mode_is_sat(input logic [1:0] mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/simd_lane_alu.sv
// Single-lane signed add/sub with wrap or saturate and an overflow flag.
// Purely combinational; the top level time-multiplexes one instance over
// all lanes.
module simd_lane_alu #(
  parameter int LANE_W = 4
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              sub,
  input  logic              sat,
  output logic [LANE_W-1:0] res,
  output logic              ovf
);

  logic [LANE_W:0]   a_ext;
  logic [LANE_W:0]   b_ext;
  logic [LANE_W:0]   sum;
  logic [LANE_W-1:0] lane_max;
  logic [LANE_W-1:0] lane_min;

  // One extra bit holds any sum/difference of two LANE_W-bit signed values
  // exactly, so overflow is simply the top two bits disagreeing.
  always_comb begin
    a_ext    = {a[LANE_W-1], a};
    b_ext    = {b[LANE_W-1], b};
    sum      = sub ? (a_ext - b_ext) : (a_ext + b_ext);
    ovf      = sum[LANE_W] ^ sum[LANE_W-1];
    lane_max = {1'b0, {(LANE_W-1){1'b1}}};
    lane_min = {1'b1, {(LANE_W-1){1'b0}}};
    res      = sum[LANE_W-1:0];
    if (sat && ovf) begin
      // The extended sign bit is the sign of the true result.
      res = sum[LANE_W] ? lane_min : lane_max;
    end
  end

endmodule

// File: rtl/simd_addsub_seq.sv
// Packed-SIMD signed add/sub engine, one lane per cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; operands/mode latched on the accepting edge
// ST_RUN  | lane idx computed each edge; last lane publishes out/ovf
module simd_addsub_seq
  import simd_pkg::*;
#(
  parameter int LANE_W = 4,
  parameter int LANES  = 2,
  parameter int DATA_W = LANE_W * LANES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [1:0]        add_or_sub,
  output logic              busy,
  output logic [DATA_W-1:0] out,
  output logic [LANES-1:0]  ovf,
  output logic              is_done
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LANES - 1);

  simd_state_t       state;
  simd_state_t       state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [1:0]        op_mode;
  logic [DATA_W-1:0] shadow;
  logic [LANES-1:0]  shadow_ovf;
  logic [DATA_W-1:0] shadow_nxt;
  logic [LANES-1:0]  shadow_ovf_nxt;
  logic [LANE_W-1:0] lane_a;
  logic [LANE_W-1:0] lane_b;
  logic [LANE_W-1:0] lane_res;
  logic              lane_ovf;
  logic              accept;
  logic              last_lane;

  assign busy      = (state == ST_RUN);
  assign accept    = (state == ST_IDLE) && start;
  assign last_lane = (idx == IDX_LAST);

  // Select the current lane's operands out of the latched vectors.
  always_comb begin
    lane_a = op_a[int'(idx)*LANE_W +: LANE_W];
    lane_b = op_b[int'(idx)*LANE_W +: LANE_W];
  end

  simd_lane_alu #(.LANE_W(LANE_W)) u_lane_alu (
    .a   (lane_a),
    .b   (lane_b),
    .sub (mode_is_sub(op_mode)),
    .sat (mode_is_sat(op_mode)),
    .res (lane_res),
    .ovf (lane_ovf)
  );

  // Merge this cycle's lane into the shadow so the last lane can be
  // published in the same edge it is computed.
  always_comb begin
    shadow_nxt     = shadow;
    shadow_ovf_nxt = shadow_ovf;
    shadow_nxt[int'(idx)*LANE_W +: LANE_W] = lane_res;
    shadow_ovf_nxt[idx]                    = lane_ovf;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start)     state_nxt = ST_RUN;
      ST_RUN:  if (last_lane) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, lane stepping, shadow accumulation and publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_mode    <= '0;
      shadow     <= '0;
      shadow_ovf <= '0;
      out        <= '0;
      ovf        <= '0;
      is_done    <= 1'b0;
    end else begin
      is_done <= 1'b0;
      if (accept) begin
        op_a    <= in1;
        op_b    <= in2;
        op_mode <= add_or_sub;
        idx     <= '0;
      end else if (busy) begin
        shadow     <= shadow_nxt;
        shadow_ovf <= shadow_ovf_nxt;
        if (last_lane) begin
          out     <= shadow_nxt;
          ovf     <= shadow_ovf_nxt;
          is_done <= 1'b1;
          idx     <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_simd_addsub_seq.sv
// Directed bench for simd_addsub_seq with LANE_W=4, LANES=2.
module tb_simd_addsub_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] in1;
  logic [7:0] in2;
  logic [1:0] add_or_sub;
  logic       busy;
  logic [7:0] out;
  logic [1:0] ovf;
  logic       is_done;

  int total;
  int bad;

  simd_addsub_seq #(.LANE_W(4), .LANES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in1        (in1),
    .in2        (in2),
    .add_or_sub (add_or_sub),
    .busy       (busy),
    .out        (out),
    .ovf        (ovf),
    .is_done    (is_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Wait (sampling on falling edges) for is_done; returns cycles waited and
  // how many of those cycles had busy high.
  task automatic wait_done(input string tag, output int cycles, output int busy_cnt);
    cycles   = 0;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cycles++;
      if (is_done === 1'b1) return;
      if (busy === 1'b1) busy_cnt++;
    end
    check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // One full operation, with inputs scrambled after acceptance.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] m, input logic [7:0] exp_out,
                        input logic [1:0] exp_ovf);
    int cyc;
    int bcnt;
    @(negedge clk);
    start = 1'b1; in1 = a; in2 = b; add_or_sub = m;
    @(negedge clk);
    start = 1'b0; in1 = ~a; in2 = ~b; add_or_sub = ~m;
    check({tag, "_busy0"}, 32'(busy), 32'd1);
    wait_done(tag, cyc, bcnt);
    check({tag, "_out"}, 32'(out), 32'(exp_out));
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    check({tag, "_lat"}, 32'(cyc), 32'd2);
    check({tag, "_busycyc"}, 32'(bcnt + 1), 32'd2);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(is_done), 32'd0);
  endtask

  initial begin
    int cyc;
    int bcnt;
    int done_seen;
    total = 0;
    bad   = 0;
    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0; add_or_sub = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_done", 32'(is_done), 32'd0);
    rst = 1'b0;

    run_op("add_basic", 8'h12, 8'h34, 2'b00, 8'h46, 2'b00);
    run_op("add_wrap",  8'h70, 8'h10, 2'b00, 8'h80, 2'b10);
    run_op("sub_wrap",  8'h35, 8'h12, 2'b01, 8'h23, 2'b00);
    run_op("add_sat",   8'h78, 8'h1F, 2'b10, 8'h78, 2'b11);
    run_op("sub_sat",   8'h87, 8'h1F, 2'b11, 8'h87, 2'b11);
    run_op("sub_wrap2", 8'h87, 8'h1F, 2'b01, 8'h78, 2'b11);
    run_op("add_sat_ok",8'h23, 8'h31, 2'b10, 8'h54, 2'b00);

    // Start while busy is ignored; start in the is_done cycle is accepted.
    @(negedge clk);
    start = 1'b1; in1 = 8'h11; in2 = 8'h11; add_or_sub = 2'b00;
    @(negedge clk);
    in1 = 8'hFF; in2 = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done("b2b_first", cyc, bcnt);
    check("b2b_first_out", 32'(out), 32'h22);
    check("b2b_first_ovf", 32'(ovf), 32'd0);
    check("b2b_first_lat", 32'(cyc), 32'd1);
    start = 1'b1; in1 = 8'h01; in2 = 8'h01;
    @(negedge clk);
    start = 1'b0;
    check("b2b_accept_busy", 32'(busy), 32'd1);
    wait_done("b2b_second", cyc, bcnt);
    check("b2b_second_out", 32'(out), 32'h02);
    check("b2b_second_lat", 32'(cyc), 32'd2);

    run_op("pre_rst", 8'h12, 8'h34, 2'b00, 8'h46, 2'b00);

    // Reset during the second RUN cycle aborts with no completion.
    @(negedge clk);
    start = 1'b1; in1 = 8'h11; in2 = 8'h22; add_or_sub = 2'b00;
    @(negedge clk);
    start = 1'b0;
    check("abort_busy1", 32'(busy), 32'd1);
    check("abort_hold", 32'(out), 32'h46);
    @(negedge clk);
    check("abort_busy2", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out", 32'(out), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    done_seen = 0;
    check("abort_done_now", 32'(is_done), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (is_done === 1'b1) done_seen = 1;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);

    run_op("post_rst", 8'h35, 8'h12, 2'b01, 8'h23, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
